// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel fixed-priority/round-robin arbiter onto one shared memory port
// One transaction in flight at a time; every output is registered.
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_read,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_byte_enable,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_resp,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [DATA_W/8-1:0]          mem_byte_enable,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_resp,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NUM_CH-1:0]   ch_resp_q, ch_resp_d;
  logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;

  logic [NUM_CH-1:0]   req;
  logic                any_req;
  logic                found;
  logic [GW-1:0]       win;
  int                  idx;

  // Winner search: round-robin starts one past the last grant, fixed starts at 0.
  always_comb begin
    req     = ch_read | ch_write;
    any_req = |req;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    if (RR_MODE != 0) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = (int'(last_grant_q) + i) % NUM_CH;
        if (!found && req[idx]) begin
          win   = GW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          win   = GW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ch_resp_d    = '0;
    ch_rdata_d   = ch_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = win;
          last_grant_d = win;
          // A channel raising both read and write is serviced as a write.
          mem_write_d  = ch_write[win];
          mem_read_d   = ~ch_write[win];
          mem_be_d     = ch_byte_enable[win*BE_W +: BE_W];
          mem_addr_d   = ch_address[win*ADDR_W +: ADDR_W];
          mem_wdata_d  = ch_wdata[win*DATA_W +: DATA_W];
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          if (!mem_write_q) begin
            ch_rdata_d = mem_rdata;
          end
          ch_resp_d[grant_q] = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CH - 1);
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ch_resp_q    <= '0;
      ch_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ch_resp_q    <= ch_resp_d;
      ch_rdata_q   <= ch_rdata_d;
    end
  end

  assign ch_resp         = ch_resp_q;
  assign ch_rdata        = ch_rdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_address     = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
// Round-robin instance runs the vector table; a fixed-priority instance checks starvation.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  rd, wr;
  logic [7:0]  be;
  logic [63:0] addr, wdata;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic        mem_read, mem_write, m_resp;
  logic [3:0]  mem_be;
  logic [31:0] mem_address, mem_wdata, m_rdata;

  logic [1:0]  f_rd, f_wr;
  logic [1:0]  f_resp;
  logic [31:0] f_rdata;
  logic        f_mem_read, f_mem_write, f_m_resp;
  logic [3:0]  f_mem_be;
  logic [31:0] f_mem_address, f_mem_wdata;

  mem_arbiter #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .ch_read(rd), .ch_write(wr), .ch_byte_enable(be), .ch_address(addr), .ch_wdata(wdata),
    .ch_resp(resp), .ch_rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_be),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(m_resp), .mem_rdata(m_rdata)
  );

  mem_arbiter #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst),
    .ch_read(f_rd), .ch_write(f_wr), .ch_byte_enable(8'hFF),
    .ch_address(64'h0000_0300_0000_0200), .ch_wdata(64'h0),
    .ch_resp(f_resp), .ch_rdata(f_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_byte_enable(f_mem_be),
    .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
    .mem_resp(f_m_resp), .mem_rdata(32'h5A5A_0001)
  );

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    int          lat;
    logic [31:0] mrdata;
    logic [1:0]  exp_resp;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_op(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_read | mem_write) && cyc < 20);
  endtask

  task automatic wait_fop(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(f_mem_read | f_mem_write) && cyc < 20);
  endtask

  initial begin
    int  cyc;
    logic stable;

    // ch1: addr 0x40, be F, wdata AABBCCDD; ch0: addr 0x100, be 0110, wdata 11223344
    addr  = {32'h0000_0040, 32'h0000_0100};
    be    = {4'b1111, 4'b0110};
    wdata = {32'hAABB_CCDD, 32'h1122_3344};
    rd = '0; wr = '0; m_resp = 1'b0; m_rdata = '0;
    f_rd = '0; f_wr = '0; f_m_resp = 1'b0;

    //         rd     wr     lat mrdata          resp   wr    addr           be       wdata
    vecs[0] = '{2'b10, 2'b00, 3, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0040, 4'hF,    32'h0};
    vecs[1] = '{2'b00, 2'b01, 2, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0000_0100, 4'b0110, 32'h1122_3344};
    vecs[2] = '{2'b11, 2'b00, 1, 32'h0000_0A01, 2'b10, 1'b0, 32'h0000_0040, 4'hF,    32'h0};
    vecs[3] = '{2'b11, 2'b00, 0, 32'h0000_0A02, 2'b01, 1'b0, 32'h0000_0100, 4'hF,    32'h0};
    vecs[4] = '{2'b11, 2'b00, 2, 32'h0000_0A03, 2'b10, 1'b0, 32'h0000_0040, 4'hF,    32'h0};
    vecs[5] = '{2'b11, 2'b00, 1, 32'h0000_0A04, 2'b01, 1'b0, 32'h0000_0100, 4'hF,    32'h0};
    vecs[6] = '{2'b01, 2'b01, 1, 32'h0BAD_0BAD, 2'b01, 1'b1, 32'h0000_0100, 4'b0110, 32'h1122_3344};
    vecs[7] = '{2'b10, 2'b00, 0, 32'h1234_5678, 2'b10, 1'b0, 32'h0000_0040, 4'hF,    32'h0};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset mem_read", mem_read, 0);
    check("reset mem_write", mem_write, 0);
    check("reset mem_address", mem_address, 0);
    check("reset mem_be", mem_be, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset ch_resp", resp, 0);
    check("reset ch_rdata", rdata, 0);
    rst = 1'b1;

    // Spurious mem_resp while idle must do nothing.
    @(negedge clk);
    m_resp = 1'b1;
    @(negedge clk);
    m_resp = 1'b0;
    check("spurious ch_resp", resp, 0);
    check("spurious mem op", {mem_read, mem_write}, 0);
    @(negedge clk);
    check("spurious ch_resp later", resp, 0);

    for (int i = 0; i < 8; i++) begin
      rd = vecs[i].rd;
      wr = vecs[i].wr;
      wait_op(cyc);
      check($sformatf("v%0d latency", i), cyc, 1);
      check($sformatf("v%0d mem_write", i), mem_write, vecs[i].exp_wr);
      check($sformatf("v%0d mem_read", i), mem_read, !vecs[i].exp_wr);
      check($sformatf("v%0d mem_address", i), mem_address, vecs[i].exp_addr);
      if (vecs[i].exp_wr) begin
        check($sformatf("v%0d mem_be", i), mem_be, vecs[i].exp_be);
        check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      end
      stable = 1'b1;
      for (int j = 0; j < vecs[i].lat; j++) begin
        @(negedge clk);
        if (mem_address !== vecs[i].exp_addr || mem_write !== vecs[i].exp_wr ||
            mem_read !== !vecs[i].exp_wr || resp !== 2'b00)
          stable = 1'b0;
      end
      check($sformatf("v%0d busy stable", i), stable, 1);
      m_rdata = vecs[i].mrdata;
      m_resp  = 1'b1;
      @(negedge clk);
      m_resp  = 1'b0;
      m_rdata = '0;
      check($sformatf("v%0d ch_resp", i), resp, vecs[i].exp_resp);
      if (!vecs[i].exp_wr)
        check($sformatf("v%0d ch_rdata", i), rdata, vecs[i].mrdata);
      check($sformatf("v%0d mem op in resp", i), {mem_read, mem_write}, 0);
      @(negedge clk);
      check($sformatf("v%0d ch_resp cleared", i), resp, 0);
    end

    // Reset while BUSY: last grant was ch1, so ch0 wins now and must win again after reset.
    rd = 2'b11;
    wr = 2'b00;
    wait_op(cyc);
    check("pre-reset latency", cyc, 1);
    check("pre-reset mem_address", mem_address, 32'h0000_0100);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async reset mem op", {mem_read, mem_write}, 0);
    check("async reset mem_address", mem_address, 0);
    check("async reset ch_resp", resp, 0);
    check("async reset ch_rdata", rdata, 0);
    @(negedge clk);
    check("in reset ch_resp", resp, 0);
    rst = 1'b1;
    wait_op(cyc);
    check("post-reset latency", cyc, 1);
    check("post-reset grant addr", mem_address, 32'h0000_0100);
    m_rdata = 32'hCAFE_F00D;
    m_resp  = 1'b1;
    @(negedge clk);
    m_resp  = 1'b0;
    check("post-reset ch_resp", resp, 2'b01);
    check("post-reset ch_rdata", rdata, 32'hCAFE_F00D);
    @(negedge clk);
    rd = 2'b00;

    // Fixed priority: both channels held, channel 0 must win every round.
    f_rd = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_fop(cyc);
      check($sformatf("fx%0d latency", t), cyc, 1);
      check($sformatf("fx%0d mem_address", t), f_mem_address, 32'h0000_0200);
      check($sformatf("fx%0d mem_read", t), {f_mem_read, f_mem_write}, 2'b10);
      @(negedge clk);
      f_m_resp = 1'b1;
      @(negedge clk);
      f_m_resp = 1'b0;
      check($sformatf("fx%0d ch_resp", t), f_resp, 2'b01);
      check($sformatf("fx%0d ch_rdata", t), f_rdata, 32'h5A5A_0001);
      @(negedge clk);
    end
    f_rd = 2'b00;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter between independent requesters (instruction fetch, load/store, future cache/DMA ports) and the single shared `mem_*` port used by the RV32I cores. It accepts the same hold-until-resp protocol on every upstream channel and serialises requests onto the memory. Each transaction is registered end to end. Arbitration is fixed-priority or round-robin, selected by parameter.

## Interface
- NUM_CH, 2, number of upstream channels (>=1)
- DATA_W, 32, data width (multiple of 8)
- ADDR_W, 32, address width
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ch_read  in  NUM_CH  per-channel read request, held until that channel's ch_resp
- ch_write  in  NUM_CH  per-channel write request, held until ch_resp
- ch_byte_enable  in  NUM_CH*DATA_W/8  packed byte enables, channel i at slice i
- ch_address  in  NUM_CH*ADDR_W  packed addresses
- ch_wdata  in  NUM_CH*DATA_W  packed write data
- ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot or zero
- ch_rdata  out  DATA_W  read data shared by all channels, valid only while a ch_resp bit is high
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_byte_enable  out  DATA_W/8  downstream byte enables
- mem_address  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_resp  in  1  downstream completion, one cycle
- mem_rdata  in  DATA_W  downstream read data, valid with mem_resp

## Operation
- States: IDLE, BUSY, RESP.
- Channel i is requesting when ch_read[i] | ch_write[i].
- IDLE:
  - If any channel is requesting, select winner g.
  - Latch g, its address, wdata, byte enable, and type. Type is write if ch_write[g], else read. Read+write together on one channel is serviced as a write.
  - Go to BUSY.
- Fixed mode: g = lowest requesting index.
- Round-robin mode:
  - Search starts at last_grant+1, modulo NUM_CH.
  - last_grant resets to NUM_CH-1, so channel 0 has first priority after reset.
  - last_grant updates only on the IDLE->BUSY transition.
- BUSY:
  - mem_read or mem_write is driven from the latched type, never both.
  - mem_address, mem_wdata, and mem_byte_enable come from latched registers and stay stable for the whole transaction.
  - Changes on ch_* inputs are ignored.
  - On mem_resp: capture mem_rdata into ch_rdata, go to RESP.
- RESP:
  - ch_resp[g]=1 for exactly this cycle; mem_read and mem_write are 0.
  - Always go to IDLE.
  - The arbiter does not sample requests in RESP, so a requester that drops its request after ch_resp is never re-granted.
- On write transactions ch_rdata holds its previous value; its contents are unspecified to consumers.
- mem_resp seen in IDLE or RESP is ignored and causes no state change.
- Grant index register width is max(1, $clog2(NUM_CH)). NUM_CH=1 degenerates to a registered pass-through with the same latency.

## Timing
- Reset (rst low, asynchronous) forces:
  - state=IDLE, last_grant=NUM_CH-1
  - mem_read=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0
  - ch_resp=0, ch_rdata=0
- Reset mid-transaction abandons the downstream access immediately. No ch_resp is issued for it.
- All outputs are registered; there is no combinational path from ch_* or mem_resp to any output.
- Latency for a request present at edge 0 (state IDLE):
  - mem_read/mem_write high from cycle 1.
  - If mem_resp arrives in cycle k (k>=1), ch_resp and ch_rdata are valid in cycle k+1.
  - The arbiter is back in IDLE in cycle k+2.
- Minimum request-to-ch_resp time: 2 cycles. Back-to-back issue interval: memory latency + 2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep their requests held and are served in later rounds.
- A new request and a mem_resp never interact in the same cycle, because requests are sampled only in IDLE.

## Test plan
- Single read, NUM_CH=2: ch_read[1]=1 with addr 0x0000_0040; memory answers 3 cycles after mem_read rises with rdata 0xDEAD_BEEF -> mem_address=0x40 in cycle 1; ch_resp=2'b10 for one cycle; ch_rdata=0xDEAD_BEEF in the same cycle.
- Fixed priority (RR_MODE=0): both channels request continuously for 4 transactions -> all 4 grants to channel 0; channel 1 starves.
- Round-robin (RR_MODE=1): both channels request continuously -> grant order 0,1,0,1; mem_address alternates between the two channels' addresses.
- Write with byte enable: ch_write[0]=1, be=4'b0110, wdata 0x1122_3344, addr 0x100 -> mem_write=1 with exactly these values, mem_read=0 for the whole transaction; ch_resp[0] pulses one cycle after mem_resp.
- Spurious mem_resp in IDLE, and a channel asserting read+write together -> no state change or ch_resp from the spurious pulse; the dual request produces mem_write=1 only.
- Async reset asserted while BUSY (between mem_read rising and mem_resp) -> all outputs 0 immediately, no ch_resp; after release, a held request is re-granted starting from channel 0.
